muldiv_ctrl: RTL and testbench
==============================

MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand width; only 32 is supported.
REQ-002 SHALL have port: clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: start  input  1  request a new operation.
REQ-005 SHALL have port: op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 SHALL have port: a  input  32  rs operand / dividend.
REQ-007 SHALL have port: b  input  32  rt operand / divisor.
REQ-008 SHALL have port: cancel  input  1  pipeline flush; abort the current operation.
REQ-009 SHALL have port: stall  output  1  pipeline hold request.
REQ-010 SHALL have port: done  output  1  one-cycle completion pulse.
REQ-011 SHALL have port: hi  output  32  product high word / remainder.
REQ-012 SHALL have port: lo  output  32  product low word / quotient.

Function
REQ-013 SHALL implement FSM states IDLE, CALC, FIX and DONE.
REQ-014 SHALL accept start only in IDLE or DONE (back-to-back operations allowed); start in CALC or FIX is ignored.
REQ-015 On acceptance at edge T, SHALL latch op and 32-bit operand magnitudes:
- signed ops: two's-complement absolute value, held 33 bits wide so 0x80000000 is exact;
- unsigned ops: operands as-is.
REQ-016 After acceptance, SHALL enter CALC with iteration counter = 0.
REQ-017 In CALC, SHALL perform one step per cycle for 32 cycles:
- multiply: radix-2 shift-add;
- divide: restoring shift-subtract.
REQ-018 SHALL leave CALC when the counter reaches 31, entering FIX at T+33.
REQ-019 In FIX, SHALL correct signs for signed ops:
- product is negated when operand signs differ;
- quotient is negated when signs differ;
- remainder takes the sign of the dividend.
REQ-020 SHALL enter DONE at T+34; done=1 for exactly that cycle, and hi/lo are valid from then on.
REQ-021 hi/lo SHALL change only on entry to DONE and hold until the next completed operation.
REQ-022 For DIV/DIVU with b==0, SHALL skip CALC and FIX and enter DONE at T+1 with lo=0xFFFFFFFF and hi=a.
REQ-023 DIV of 0x80000000 by 0xFFFFFFFF SHALL yield lo=0x80000000, hi=0 (natural wrap, no trap).
REQ-024 stall SHALL be combinational: 1 when start is accepted this cycle, or while the state is CALC or FIX; otherwise 0 (0 in DONE).
REQ-025 cancel=1 SHALL force IDLE at the next edge from any state:
- no done pulse is produced;
- hi/lo are unchanged;
- cancel wins over a simultaneous start;
- stall is 0 during a cycle with cancel=1.
REQ-026 Arithmetic SHALL be unsigned on magnitudes with a 64-bit accumulator; no latch inference and no multi-cycle paths.

Reset
REQ-027 rst=1 SHALL asynchronously force: state IDLE, counter 0, hi=0, lo=0, done=0, all internal operand and accumulator registers 0.
REQ-028 stall SHALL evaluate to 0 during reset.
REQ-029 Reset mid-operation SHALL discard the operation; no done pulse follows deassertion.

Structure
REQ-030 Op encodings and the FSM state enum SHALL reside in shared package muldiv_pkg, which the decode stage also uses.
REQ-031 One sub-module, div_step (combinational one-bit restoring subtract: partial remainder and divisor in, next remainder and quotient bit out), SHALL be instantiated.
REQ-032 The multiply step SHALL remain inline.

Verification
REQ-033 MULT a=0xFFFFFFFD b=5 -> at T+34 done=1, hi=0xFFFFFFFF, lo=0xFFFFFFF1; stall=1 from T through T+33.
REQ-034 MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001 at T+34.
REQ-035 Divide cases:
- DIVU 100/7 -> lo=14, hi=2;
- DIV 0xFFFFFFF9/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF;
- DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-036 DIV a=0x1234 b=0 -> done at T+1, lo=0xFFFFFFFF, hi=0x1234.
REQ-037 Start at T, cancel at T+10 -> IDLE at T+11, no done, stall=0, hi/lo retain previous values; a start at T+11 completes normally at T+45.
REQ-038 rst pulsed at T+20 mid-DIVU -> all outputs 0 immediately; no done after release.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states
// and small decode helpers also used by the decode stage.
package muldiv_pkg;

  localparam int unsigned CNT_W = 5;
  localparam logic [CNT_W-1:0] LAST_STEP = 5'd31;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  function automatic logic op_is_div(input logic [1:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_div_step.sv
// One restoring-division step: trial-subtract the divisor from the shifted
// partial remainder and keep the difference only when it did not go negative.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] diff;

  // rem_in < 2*divisor, so the difference always fits in WIDTH+1 bits signed.
  always_comb begin
    diff    = rem_in - {1'b0, divisor};
    q_bit   = ~diff[WIDTH];
    rem_out = q_bit ? diff[WIDTH-1:0] : rem_in[WIDTH-1:0];
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// Iterative MULT/MULTU/DIV/DIVU unit: 32 one-bit steps on operand magnitudes,
// then a sign-fix cycle; stalls the pipeline while busy, cancellable by flush.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               div_q, div_d;
  logic               neg_q, neg_d;
  logic               negr_q, negr_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic               accept;
  logic               sgn_in;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next, div_next, prod;
  logic [WIDTH:0]     rem_shift;
  logic [WIDTH-1:0]   rem_out;
  logic               q_bit;

  div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_in  (rem_shift),
    .divisor (mcand_q),
    .rem_out (rem_out),
    .q_bit   (q_bit)
  );

  // Magnitude of 0x80000000 is 0x80000000, exact as an unsigned 32-bit value.
  always_comb begin
    accept = start && !cancel && (state_q == ST_IDLE || state_q == ST_DONE);
    stall  = !rst && !cancel &&
             (accept || state_q == ST_CALC || state_q == ST_FIX);
    done   = (state_q == ST_DONE);
    sgn_in = op_is_signed(op);
    a_mag  = (sgn_in && a[WIDTH-1]) ? -a : a;
    b_mag  = (sgn_in && b[WIDTH-1]) ? -b : b;

    // acc = {partial high word, multiplier being shifted out}
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // acc = {partial remainder, dividend being shifted in / quotient shifted out}
    rem_shift = acc_q[2*WIDTH-1:WIDTH-1];
    div_next  = {rem_out, acc_q[WIDTH-2:0], q_bit};

    prod = neg_q ? -acc_q : acc_q;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    neg_d   = neg_q;
    negr_d  = negr_q;
    mcand_d = mcand_q;
    acc_d   = acc_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    if (cancel) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          state_d = ST_IDLE;
          if (accept) begin
            div_d   = op_is_div(op);
            neg_d   = sgn_in && (a[WIDTH-1] ^ b[WIDTH-1]);
            negr_d  = sgn_in && a[WIDTH-1];
            mcand_d = b_mag;
            acc_d   = {{WIDTH{1'b0}}, a_mag};
            cnt_d   = '0;
            if (op_is_div(op) && b == '0) begin
              state_d = ST_DONE;
              hi_d    = a;
              lo_d    = '1;
            end else begin
              state_d = ST_CALC;
            end
          end
        end
        ST_CALC: begin
          acc_d = div_q ? div_next : mul_next;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_STEP) state_d = ST_FIX;
        end
        ST_FIX: begin
          state_d = ST_DONE;
          if (div_q) begin
            lo_d = neg_q  ? -acc_q[WIDTH-1:0]       : acc_q[WIDTH-1:0];
            hi_d = negr_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
          end else begin
            lo_d = prod[WIDTH-1:0];
            hi_d = prod[2*WIDTH-1:WIDTH];
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      div_q   <= 1'b0;
      neg_q   <= 1'b0;
      negr_q  <= 1'b0;
      mcand_q <= '0;
      acc_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      neg_q   <= neg_d;
      negr_q  <= negr_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Bench for muldiv_ctrl: vector table, back-to-back, cancel, reset and
// random operations checked against a behavioural model through a queue.
module tb_muldiv_ctrl;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        cancel;
  logic        stall, done;
  logic [31:0] hi, lo;

  int n_total = 0;
  int n_pass  = 0;
  logic [63:0] exp_q[$];
  logic [63:0] last_exp = 64'd0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs[NV];

  muldiv_ctrl #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .cancel(cancel), .stall(stall), .done(done), .hi(hi), .lo(lo)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: actual=%h required=%h", name, act, exp);
    else n_pass++;
  endtask

  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    logic signed [63:0] sx, sy;
    logic signed [31:0] qx, qy;
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    qx = x;
    qy = y;
    case (o)
      OP_MULT:  return sx * sy;
      OP_MULTU: return {32'd0, x} * {32'd0, y};
      OP_DIV: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        return {32'(qx % qy), 32'(qx / qy)};
      end
      default: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        return {x % y, x / y};
      end
    endcase
  endfunction

  // driver: called inside a cycle (after its negedge), leaves start high
  task automatic issue(input logic [1:0] o, input logic [31:0] ia, input logic [31:0] ib,
                       input logic [63:0] exp, input bit push);
    start = 1'b1; op = o; a = ia; b = ib;
    if (push) exp_q.push_back(exp);
    #1;
    check("stall_accept", {63'd0, stall}, 64'd1);
  endtask

  // counts cycles from the issue cycle until done, then scoreboards hi/lo
  task automatic wait_done(input int lat);
    int cyc = 0;
    bit seen = 0;
    bit stall_ok = 1;
    logic [63:0] e;
    while (!seen && cyc < 100) begin
      @(negedge clk); start = 1'b0; #1; cyc++;
      if (done) seen = 1;
      else if (cyc < lat && !stall) stall_ok = 0;
    end
    check("done_latency", seen ? 64'(cyc) : 64'd999, 64'(lat));
    if (lat > 1) check("stall_busy", {63'd0, stall_ok}, 64'd1);
    check("stall_in_done", {63'd0, stall}, 64'd0);
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      last_exp = e;
      check("result_hi_lo", {hi, lo}, e);
    end
  endtask

  task automatic expect_no_done(input int cycles, input string name);
    bit saw = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk); start = 1'b0; #1;
      if (done) saw = 1;
    end
    check(name, {63'd0, saw}, 64'd0);
  endtask

  initial begin
    vecs[0]  = '{OP_MULT,  32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1, 34};
    vecs[1]  = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 34};
    vecs[2]  = '{OP_DIVU,  32'd100,       32'd7,        32'd2,         32'd14,        34};
    vecs[3]  = '{OP_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 34};
    vecs[4]  = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 34};
    vecs[5]  = '{OP_DIV,   32'h0000_1234, 32'd0,        32'h0000_1234, 32'hFFFF_FFFF, 1};
    vecs[6]  = '{OP_DIVU,  32'd5,         32'd0,        32'd5,         32'hFFFF_FFFF, 1};
    vecs[7]  = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 34};
    vecs[8]  = '{OP_MULT,  32'd7,         32'hFFFF_FFFA, 32'hFFFF_FFFF, 32'hFFFF_FFD6, 34};
    vecs[9]  = '{OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 34};
    vecs[10] = '{OP_DIVU,  32'hFFFF_FFFF, 32'd1,        32'd0,         32'hFFFF_FFFF, 34};

    rst = 1'b1; start = 1'b1; op = OP_MULT; a = 32'd3; b = 32'd4; cancel = 1'b0;
    #2;
    check("reset_hi_lo", {hi, lo}, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
    check("reset_stall", {63'd0, stall}, 64'd0);
    @(negedge clk); start = 1'b0;
    @(negedge clk); rst = 1'b0;

    // table-driven vectors
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      issue(vecs[i].op, vecs[i].a, vecs[i].b, {vecs[i].hi, vecs[i].lo}, 1);
      wait_done(vecs[i].lat);
      @(negedge clk); #1;
      check("done_one_cycle", {63'd0, done}, 64'd0);
      check("hold_hi_lo", {hi, lo}, {vecs[i].hi, vecs[i].lo});
    end

    // back-to-back: new start accepted in the DONE cycle
    @(negedge clk);
    issue(OP_MULTU, 32'd3, 32'd4, 64'd12, 1);
    wait_done(34);
    issue(OP_DIVU, 32'd100, 32'd7, {32'd2, 32'd14}, 1);
    wait_done(34);
    issue(OP_DIV, 32'h1234, 32'd0, {32'h1234, 32'hFFFF_FFFF}, 1);
    wait_done(1);

    // cancel at T+10, restart at T+11 completes at T+45
    @(negedge clk);
    issue(OP_DIVU, 32'd1000, 32'd3, 64'd0, 0);
    expect_no_done(9, "no_done_before_cancel");
    @(negedge clk); cancel = 1'b1; #1;
    check("stall_cancel", {63'd0, stall}, 64'd0);
    @(negedge clk); cancel = 1'b0; #1;
    check("cancel_no_done", {63'd0, done}, 64'd0);
    check("cancel_idle_stall", {63'd0, stall}, 64'd0);
    check("cancel_hold_hi_lo", {hi, lo}, last_exp);
    issue(OP_MULTU, 32'd6, 32'd7, 64'd42, 1);
    wait_done(34);

    // cancel wins over a simultaneous start
    @(negedge clk); start = 1'b1; cancel = 1'b1; op = OP_MULT; a = 32'd9; b = 32'd9; #1;
    check("stall_cancel_start", {63'd0, stall}, 64'd0);
    @(negedge clk); cancel = 1'b0; start = 1'b0; #1;
    check("cancel_start_idle", {63'd0, stall}, 64'd0);
    expect_no_done(40, "cancel_start_no_done");
    check("cancel_start_hold", {hi, lo}, last_exp);

    // random operations against the model
    for (int r = 0; r < 16; r++) begin
      logic [1:0]  ro;
      logic [31:0] ra, rb;
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 20));
      @(negedge clk);
      issue(ro, ra, rb, model(ro, ra, rb), 1);
      wait_done((op_is_div(ro) && rb == 32'd0) ? 1 : 34);
    end

    // reset mid-DIVU at T+20
    @(negedge clk);
    issue(OP_DIVU, 32'hFFFF_FFFF, 32'd3, 64'd0, 0);
    expect_no_done(19, "no_done_before_reset");
    #1; rst = 1'b1; #1;
    check("midop_reset_hi_lo", {hi, lo}, 64'd0);
    check("midop_reset_done", {63'd0, done}, 64'd0);
    check("midop_reset_stall", {63'd0, stall}, 64'd0);
    @(negedge clk); rst = 1'b0;
    expect_no_done(40, "reset_no_done");
    check("reset_idle_stall", {63'd0, stall}, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
